// File: rtl/ddram_pkg.sv
// Shared types, bus widths and beat helpers for the DDRAM block-RAM responder.
package ddram_pkg;

  localparam int DDRAM_ADDR_W = 29;
  localparam int DDRAM_DATA_W = 64;
  localparam int DDRAM_BE_W   = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    READ_WAIT   = 2'd2,
    HOLD        = 2'd3
  } state_e;

  // A beat is local when its offset from the window base fits in the RAM index.
  function automatic logic in_window(input logic [DDRAM_ADDR_W-1:0] addr,
                                     input logic [DDRAM_ADDR_W-1:0] base,
                                     input int                      aw);
    logic [DDRAM_ADDR_W-1:0] off;
    off = addr - base;
    return ((off >> aw) == {DDRAM_ADDR_W{1'b0}});
  endfunction

  function automatic logic [7:0] eff_count(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd1 : cnt;
  endfunction

endpackage

// File: rtl/ddram_bram.sv
// Single-port 64-bit RAM with byte-enable writes and a registered, write-first read.
module ddram_bram
  import ddram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DDRAM_BE_W-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DDRAM_DATA_W-1:0] din,
  output logic [DDRAM_DATA_W-1:0] dout
);

  logic [DDRAM_DATA_W-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DDRAM_DATA_W-1:0] rdata_q;
  logic [DDRAM_DATA_W-1:0] merged_s;

  // Word as it will look after the byte-enabled write; returned on collision.
  always_comb begin
    merged_s = mem[addr];
    for (int i = 0; i < DDRAM_BE_W; i++) begin
      merged_s[8*i +: 8] = be[i] ? din[8*i +: 8] : mem[addr][8*i +: 8];
    end
  end

  // RAM array and registered read port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DDRAM_BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= din[8*i +: 8];
          end
        end
        rdata_q <= merged_s;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign dout = rdata_q;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM_* responder serving single/burst commands from block RAM with
// programmable wait states and read latency.
module ddram_responder
  import ddram_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [28:0] BASE         = 29'h0C000000,
  parameter int          BUSY_CYCLES  = 1,
  parameter int          READ_LATENCY = 2
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic        err_oow,
  output logic        err_proto,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] HOLD_LOAD = (BUSY_CYCLES > 0) ? 4'(BUSY_CYCLES - 1) : 4'd0;
  localparam logic [3:0] WAIT_LOAD = (READ_LATENCY > 2) ? 4'(READ_LATENCY - 3) : 4'd0;
  localparam state_e     AFTER_ST  = (BUSY_CYCLES == 0) ? IDLE : HOLD;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic [28:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  hold_q, hold_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_oow_q, rd_oow_d;
  logic        rd_last_q, rd_last_d;
  logic [63:0] dout_q, dout_d;
  logic        dout_ready_q, dout_ready_d;
  logic        dout_last_q, dout_last_d;
  logic        err_oow_q, err_oow_d;
  logic        err_proto_q, err_proto_d;

  logic [7:0]  req_cnt_s;
  logic [28:0] beat_addr_s;
  logic [28:0] issue_addr_s;
  logic        issue_rd_s;
  logic        issue_wr_s;
  logic        issue_last_s;
  logic        issue_inwin_s;
  logic        ram_en_s;
  logic        ram_we_s;
  logic [63:0] ram_rdata_s;

  assign req_cnt_s   = eff_count(DDRAM_BURSTCNT);
  assign beat_addr_s = addr_q + {21'd0, beat_q};

  // Command FSM, per-beat issue, window/error tracking and the read return stage.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    hold_d       = hold_q;
    err_proto_d  = err_proto_q;
    issue_addr_s = beat_addr_s;
    issue_rd_s   = 1'b0;
    issue_wr_s   = 1'b0;
    issue_last_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (DDRAM_RD && !busy_q) begin
          // Read wins over a simultaneous write; the write data is dropped.
          addr_d  = DDRAM_ADDR;
          cnt_d   = req_cnt_s;
          wait_d  = WAIT_LOAD;
          state_d = READ_WAIT;
          if (DDRAM_WE || (DDRAM_BURSTCNT == 8'd0)) begin
            err_proto_d = 1'b1;
          end else begin
            err_proto_d = err_proto_q;
          end
          if (READ_LATENCY == 2) begin
            issue_rd_s   = 1'b1;
            issue_addr_s = DDRAM_ADDR;
            issue_last_s = (req_cnt_s == 8'd1);
            beat_d       = 8'd1;
          end else begin
            beat_d = 8'd0;
          end
        end else if (DDRAM_WE && !busy_q) begin
          issue_wr_s   = 1'b1;
          issue_addr_s = DDRAM_ADDR;
          if (DDRAM_BURSTCNT == 8'd0) begin
            err_proto_d = 1'b1;
          end else begin
            err_proto_d = err_proto_q;
          end
          if (req_cnt_s > 8'd1) begin
            addr_d  = DDRAM_ADDR;
            cnt_d   = req_cnt_s;
            beat_d  = 8'd1;
            state_d = WRITE_BURST;
          end else begin
            hold_d  = HOLD_LOAD;
            state_d = AFTER_ST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_BURST: begin
        if (DDRAM_RD) begin
          err_proto_d = 1'b1;
        end else begin
          err_proto_d = err_proto_q;
        end
        if (DDRAM_WE) begin
          issue_wr_s = 1'b1;
          if (beat_q == (cnt_q - 8'd1)) begin
            hold_d  = HOLD_LOAD;
            state_d = AFTER_ST;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          state_d = WRITE_BURST;
        end
      end
      READ_WAIT: begin
        if (dout_last_q) begin
          hold_d  = HOLD_LOAD;
          state_d = AFTER_ST;
        end else if (beat_q != cnt_q) begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            issue_rd_s   = 1'b1;
            issue_last_s = (beat_q == (cnt_q - 8'd1));
            beat_d       = beat_q + 8'd1;
          end
        end else begin
          state_d = READ_WAIT;
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    issue_inwin_s = in_window(issue_addr_s, BASE, ADDR_WIDTH);
    ram_en_s      = (issue_rd_s || issue_wr_s) && issue_inwin_s;
    ram_we_s      = issue_wr_s && issue_inwin_s;
    err_oow_d     = err_oow_q | ((issue_rd_s || issue_wr_s) && !issue_inwin_s);

    rd_pend_d    = issue_rd_s;
    rd_oow_d     = issue_rd_s && !issue_inwin_s;
    rd_last_d    = issue_rd_s && issue_last_s;
    dout_ready_d = rd_pend_q;
    dout_last_d  = rd_pend_q && rd_last_q;
    if (rd_pend_q) begin
      dout_d = rd_oow_q ? 64'd0 : ram_rdata_s;
    end else begin
      dout_d = dout_q;
    end

    busy_d = (state_d == READ_WAIT) || (state_d == HOLD);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b1;
      addr_q       <= 29'd0;
      cnt_q        <= 8'd0;
      beat_q       <= 8'd0;
      wait_q       <= 4'd0;
      hold_q       <= 4'd0;
      rd_pend_q    <= 1'b0;
      rd_oow_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      dout_q       <= 64'd0;
      dout_ready_q <= 1'b0;
      dout_last_q  <= 1'b0;
      err_oow_q    <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      hold_q       <= hold_d;
      rd_pend_q    <= rd_pend_d;
      rd_oow_q     <= rd_oow_d;
      rd_last_q    <= rd_last_d;
      dout_q       <= dout_d;
      dout_ready_q <= dout_ready_d;
      dout_last_q  <= dout_last_d;
      err_oow_q    <= err_oow_d;
      err_proto_q  <= err_proto_d;
    end
  end

  ddram_bram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk (DDRAM_CLK),
    .en  (ram_en_s),
    .we  (ram_we_s),
    .be  (DDRAM_BE),
    .addr(issue_addr_s[ADDR_WIDTH-1:0]),
    .din (DDRAM_DIN),
    .dout(ram_rdata_s)
  );

  assign DDRAM_BUSY       = busy_q;
  assign DDRAM_DOUT       = dout_q;
  assign DDRAM_DOUT_READY = dout_ready_q;
  assign err_oow          = err_oow_q;
  assign err_proto        = err_proto_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ddram_responder.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a word-array memory model.
module tb_ddram_responder;

  localparam logic [28:0] BASE = 29'h0C000000;
  localparam int          BC   = 1;
  localparam int          RL   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        BUSY;
  logic [7:0]  BURSTCNT = 8'd1;
  logic [28:0] ADDR = 29'd0;
  logic        RD = 1'b0;
  logic        WE = 1'b0;
  logic [63:0] DIN = 64'd0;
  logic [7:0]  BE = 8'hFF;
  logic [63:0] DOUT;
  logic        DOUT_READY;
  logic        err_oow;
  logic        err_proto;
  logic [1:0]  dbg_state;

  ddram_responder #(
    .ADDR_WIDTH(12), .BASE(BASE), .BUSY_CYCLES(BC), .READ_LATENCY(RL)
  ) dut (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(BUSY), .DDRAM_BURSTCNT(BURSTCNT),
    .DDRAM_ADDR(ADDR), .DDRAM_RD(RD), .DDRAM_WE(WE), .DDRAM_DIN(DIN), .DDRAM_BE(BE),
    .DDRAM_DOUT(DOUT), .DDRAM_DOUT_READY(DOUT_READY), .err_oow(err_oow),
    .err_proto(err_proto), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mdl [0:4095];
  bit          known [0:4095];
  bit          exp_oow = 1'b0;
  bit          exp_proto = 1'b0;
  logic [63:0] wr_data [0:15];
  logic [63:0] rd_got [0:255];

  typedef struct {
    logic [28:0] addr;
    logic [63:0] pre;
    logic [63:0] din;
    logic [7:0]  be;
    logic [63:0] exp;
    logic        exp_oow;
  } vec_t;
  vec_t vt [0:5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit m_in(input logic [28:0] a);
    logic [28:0] off;
    off = a - BASE;
    return off < 29'd4096;
  endfunction

  task automatic m_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    int idx;
    if (!m_in(a)) begin
      exp_oow = 1'b1;
    end else begin
      idx = int'(a - BASE);
      for (int i = 0; i < 8; i++) if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      if (be == 8'hFF) known[idx] = 1'b1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (BUSY !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 64'(BUSY), 64'd0);
  endtask

  task automatic do_write(input logic [28:0] a, input int cnt, input logic [7:0] be);
    wait_ready();
    WE = 1'b1; RD = 1'b0; ADDR = a; BURSTCNT = 8'(cnt); BE = be; DIN = wr_data[0];
    m_write(a, wr_data[0], be);
    for (int i = 1; i < cnt; i++) begin
      @(negedge clk);
      chk("wr_burst_busy", 64'(BUSY), 64'd0);
      DIN = wr_data[i];
      m_write(a + 29'(i), wr_data[i], be);
    end
    @(negedge clk);
    WE = 1'b0;
    for (int j = 0; j < BC; j++) begin
      chk("wr_hold_busy", 64'(BUSY), 64'd1);
      @(negedge clk);
    end
    chk("wr_idle_busy", 64'(BUSY), 64'd0);
  endtask

  task automatic do_read(input logic [28:0] a, input logic [7:0] cnt, input bit also_we);
    int ncnt, beats, first_n, last_n, busy_bad, limit, idx;
    logic [28:0] ba;
    logic        exp_b;
    ncnt = (cnt == 8'd0) ? 1 : int'(cnt);
    if (cnt == 8'd0 || also_we) exp_proto = 1'b1;
    for (int b = 0; b < ncnt; b++) if (!m_in(a + 29'(b))) exp_oow = 1'b1;
    wait_ready();
    RD = 1'b1; WE = also_we; ADDR = a; BURSTCNT = cnt; BE = 8'hFF; DIN = {$urandom, $urandom};
    @(negedge clk);
    RD = 1'b0; WE = 1'b0;
    beats = 0; first_n = -1; last_n = -1; busy_bad = 0;
    limit = RL + ncnt + BC + 3;
    for (int n = 1; n <= limit; n++) begin
      if (DOUT_READY === 1'b1) begin
        if (beats == 0) first_n = n;
        last_n = n;
        if (beats < 256) rd_got[beats] = DOUT;
        if (beats < ncnt) begin
          ba = a + 29'(beats);
          if (!m_in(ba)) begin
            chk("rd_oow_data", DOUT, 64'd0);
          end else begin
            idx = int'(ba - BASE);
            if (known[idx]) chk("rd_data", DOUT, mdl[idx]);
          end
        end
        beats++;
      end
      exp_b = (n <= RL + ncnt - 1 + BC) ? 1'b1 : 1'b0;
      if (BUSY !== exp_b) busy_bad++;
      @(negedge clk);
    end
    chk("rd_first_latency", 64'(first_n), 64'(RL));
    chk("rd_beat_count", 64'(beats), 64'(ncnt));
    chk("rd_consecutive", 64'(last_n - first_n + 1), 64'(ncnt));
    chk("rd_busy_profile", 64'(busy_bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, extra, r, cnt;
    logic [28:0] a;
    logic [7:0]  be;

    vt[0] = '{29'h0C000005, 64'h0, 64'h1122334455667788, 8'hFF, 64'h1122334455667788, 1'b0};
    vt[1] = '{29'h0C000000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 8'b0000_0100, 64'h0000000000FF0000, 1'b0};
    vt[2] = '{29'h0C000FFF, 64'hAAAAAAAAAAAAAAAA, 64'h0123456789ABCDEF, 8'h0F, 64'hAAAAAAAA89ABCDEF, 1'b0};
    vt[3] = '{29'h0C000010, 64'h5555555555555555, 64'h0, 8'h00, 64'h5555555555555555, 1'b0};
    vt[4] = '{29'h0C001000, 64'h1, 64'h2, 8'hFF, 64'h0, 1'b1};
    vt[5] = '{29'h0BFFFFFF, 64'h3, 64'h4, 8'hFF, 64'h0, 1'b1};

    // Reset values, then release
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(BUSY), 64'd1);
    chk("rst_dout", DOUT, 64'd0);
    chk("rst_dout_ready", 64'(DOUT_READY), 64'd0);
    chk("rst_err_oow", 64'(err_oow), 64'd0);
    chk("rst_err_proto", 64'(err_proto), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    #1 chk("rel_busy_held", 64'(BUSY), 64'd1);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      wr_data[0] = vt[i].pre;
      do_write(vt[i].addr, 1, 8'hFF);
      wr_data[0] = vt[i].din;
      do_write(vt[i].addr, 1, vt[i].be);
      do_read(vt[i].addr, 8'd1, 1'b0);
      chk("vec_dout", rd_got[0], vt[i].exp);
      chk("vec_err_oow", 64'(err_oow), 64'(vt[i].exp_oow));
    end

    // Burst straddling the top of the window
    for (int i = 0; i < 4; i++) wr_data[i] = 64'(i + 1);
    do_write(29'h0C000FFE, 4, 8'hFF);
    do_read(29'h0C000FFE, 8'd4, 1'b0);
    chk("burst_b0", rd_got[0], 64'd1);
    chk("burst_b1", rd_got[1], 64'd2);
    chk("burst_b2", rd_got[2], 64'd0);
    chk("burst_b3", rd_got[3], 64'd0);
    chk("burst_err_oow", 64'(err_oow), 64'd1);

    // Protocol violations
    chk("pre_err_proto", 64'(err_proto), 64'd0);
    do_read(29'h0C000010, 8'd1, 1'b1);
    chk("rdwe_read_served", rd_got[0], 64'h5555555555555555);
    chk("rdwe_err_proto", 64'(err_proto), 64'd1);
    do_read(29'h0C000010, 8'd1, 1'b0);
    chk("rdwe_write_dropped", rd_got[0], 64'h5555555555555555);
    do_read(29'h0C000005, 8'd0, 1'b0);
    chk("cnt0_data", rd_got[0], 64'h1122334455667788);

    // Maximum-length burst
    do_read(BASE, 8'd255, 1'b0);

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + 29'($urandom_range(0, 4095));
      else if (r == 8) a = BASE + 29'(4092 + $urandom_range(0, 7));
      else a = BASE - 29'($urandom_range(1, 3));
      cnt = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < cnt; i++) wr_data[i] = {$urandom, $urandom};
        be = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        do_write(a, cnt, be);
      end else begin
        do_read(a, 8'(cnt), 1'b0);
      end
    end
    chk("rand_err_oow", 64'(err_oow), 64'(exp_oow));
    chk("rand_err_proto", 64'(err_proto), 64'(exp_proto));

    // Reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) wr_data[i] = {$urandom, $urandom};
    do_write(BASE + 29'h100, 8, 8'hFF);
    wait_ready();
    RD = 1'b1; ADDR = BASE + 29'h100; BURSTCNT = 8'd8;
    @(negedge clk);
    RD = 1'b0;
    n = 0;
    while (DOUT_READY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_first_beat", 64'(DOUT_READY), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_dout_ready", 64'(DOUT_READY), 64'd0);
    chk("mid_rst_busy", 64'(BUSY), 64'd1);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_dout", DOUT, 64'd0);
    exp_oow = 1'b0;
    exp_proto = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("mid_rel_busy_held", 64'(BUSY), 64'd1);
    @(posedge clk);
    #1 chk("mid_rel_busy_drop", 64'(BUSY), 64'd0);
    chk("mid_rel_err_oow", 64'(err_oow), 64'd0);
    chk("mid_rel_err_proto", 64'(err_proto), 64'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (DOUT_READY === 1'b1) extra++;
    end
    chk("mid_no_more_beats", 64'(extra), 64'd0);
    do_read(BASE + 29'h100, 8'd8, 1'b0);
    do_read(29'h0C000005, 8'd1, 1'b0);
    chk("mid_ram_intact", rd_got[0], 64'h1122334455667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
